// File: rtl/frequency_generator_if.sv
// Bus between a frequency_generator and whatever programs and observes it.
// The master side programs the rate; the slave side (the generator) drives the outputs.
interface frequency_generator_if;
  logic [6:0] freq;
  logic       freq_load;
  logic       signal;
  logic       window_start;
  logic [6:0] active_freq;

  modport master (
    output freq,
    output freq_load,
    input  signal,
    input  window_start,
    input  active_freq
  );

  modport slave (
    input  freq,
    input  freq_load,
    output signal,
    output window_start,
    output active_freq
  );
endinterface

// File: rtl/frequency_generator.sv
// Test-signal source for the frequency counter: emits exactly N rising edges per
// UPDATE_PERIOD-cycle window, evenly spread by a Bresenham accumulator.
// N is reloaded from the pending register only at window cycle 0.
// As a result, a rate change never produces a partial window.
module frequency_generator #(
  parameter int unsigned UPDATE_PERIOD = 12000,
  parameter int unsigned BITS          = 14,
  parameter int unsigned PULSE_WIDTH   = 4
) (
  input logic                  clk,
  input logic                  reset,
  frequency_generator_if.slave bus
);

  localparam int unsigned PwBits = $clog2(PULSE_WIDTH + 1);
  localparam logic [BITS-1:0]   PeriodVal = BITS'(UPDATE_PERIOD);
  localparam logic [BITS-1:0]   PeriodM1  = BITS'(UPDATE_PERIOD - 1);
  localparam logic [PwBits-1:0] PwVal     = PwBits'(PULSE_WIDTH);
  localparam logic [6:0]        FreqMax   = 7'd99;

  logic [BITS-1:0]   win_cnt_q;
  logic [BITS-1:0]   acc_q;
  logic [6:0]        pending_q;
  logic [6:0]        active_freq_q;
  logic [PwBits-1:0] pulse_cnt_q;
  logic              signal_q;
  logic              window_start_q;

  logic              win_start;
  logic [6:0]        freq_clamped;
  logic [6:0]        n_eff;
  logic [BITS-1:0]   acc_base;
  logic [BITS-1:0]   sum;
  logic              event_hit;
  logic [BITS-1:0]   acc_d;

  // Accumulator step; at window cycle 0 the new N and the P-1 base are used directly,
  // which places the first event at cycle 0 whenever N >= 1.
  always_comb begin
    win_start    = (win_cnt_q == '0);
    freq_clamped = (bus.freq > FreqMax) ? FreqMax : bus.freq;
    n_eff        = win_start ? pending_q : active_freq_q;
    acc_base     = win_start ? PeriodM1 : acc_q;
    sum          = acc_base + BITS'(n_eff);
    event_hit    = (sum >= PeriodVal);
    acc_d        = event_hit ? (sum - PeriodVal) : sum;
  end

  // Window counter, rate registers, accumulator and pulse shaper.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q      <= '0;
      acc_q          <= '0;
      pending_q      <= '0;
      active_freq_q  <= '0;
      pulse_cnt_q    <= '0;
      signal_q       <= 1'b0;
      window_start_q <= 1'b0;
    end else begin
      win_cnt_q      <= (win_cnt_q == PeriodM1) ? '0 : win_cnt_q + BITS'(1);
      window_start_q <= win_start;
      if (win_start) begin
        active_freq_q <= pending_q;
      end
      // A load in cycle 0 lands after N has already sampled pending, so it waits a window.
      if (bus.freq_load) begin
        pending_q <= freq_clamped;
      end
      acc_q    <= acc_d;
      // signal follows the counter one cycle late: high for exactly PULSE_WIDTH cycles.
      signal_q <= (pulse_cnt_q != '0);
      if (event_hit) begin
        pulse_cnt_q <= PwVal;
      end else if (pulse_cnt_q != '0) begin
        pulse_cnt_q <= pulse_cnt_q - PwBits'(1);
      end
    end
  end

  assign bus.signal       = signal_q;
  assign bus.window_start = window_start_q;
  assign bus.active_freq  = active_freq_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Randomized self-checking bench for frequency_generator.
// The reference model counts events per window in closed form: floor((P-1 + (k+1)*N) / P).
module tb_frequency_generator;

  localparam int P  = 12000;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic reset;

  frequency_generator_if bus ();

  frequency_generator #(
    .UPDATE_PERIOD(P),
    .BITS         (14),
    .PULSE_WIDTH  (PW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_k       = 0;     // window cycle the next edge processes
  int m_cur_k   = -1;    // window cycle processed at the last edge (-1: reset)
  int m_pending = 0;
  int m_n       = 0;
  int m_prev_n  = 0;
  int m_since   = 1000;  // edges since the last event
  int exp_sig   = 0;
  int exp_ws    = 0;
  int exp_af    = 0;

  // Observation state
  logic prev_sig  = 1'b0;
  int   rises     = 0;
  int   last_rise = -1;
  int   min_gap   = 1000000;
  int   max_gap   = 0;
  int   hi_len    = 0;
  bit   win_valid = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int events_through(input int k, input int n);
    return (P - 1 + k * n) / P;
  endfunction

  // Advance the model over one clock edge with the given inputs.
  task automatic model_edge(input logic rst, input logic ld, input int f);
    int ev;
    if (rst) begin
      m_k = 0; m_cur_k = -1; m_pending = 0; m_n = 0;
      m_since = 1000; exp_sig = 0; exp_ws = 0; exp_af = 0;
    end else begin
      m_cur_k = m_k;
      if (m_k == 0) begin
        m_prev_n = m_n;
        m_n      = m_pending;
      end
      ev = events_through(m_k + 1, m_n) - events_through(m_k, m_n);
      if (ld) m_pending = (f > 99) ? 99 : f;
      if (m_since < 1000) m_since++;
      exp_sig = (m_since >= 1 && m_since <= PW) ? 1 : 0;
      if (ev != 0) m_since = 0;
      exp_ws = (m_k == 0) ? 1 : 0;
      exp_af = m_n;
      m_k    = (m_k + 1) % P;
    end
  endtask

  // Compare the sampled outputs and update edge statistics.
  task automatic observe();
    check_eq("signal", int'(bus.signal), exp_sig);
    check_eq("window_start", int'(bus.window_start), exp_ws);
    check_eq("active_freq", int'(bus.active_freq), exp_af);
    if (m_cur_k == -1) begin
      win_valid = 1'b0;
    end else if (m_cur_k == 0) begin
      if (win_valid) begin
        check_eq("edges_per_window", rises, m_prev_n);
        if (m_prev_n == 99) begin
          check_eq("min_rise_gap", min_gap, 121);
          check_eq("max_rise_gap", max_gap, 122);
        end
      end
      rises = 0; last_rise = -1; min_gap = 1000000; max_gap = 0;
      win_valid = 1'b1;
    end
    if (bus.signal && !prev_sig && m_cur_k > 0) begin
      if (rises == 0) begin
        check_eq("first_edge_cycle", m_cur_k, 1);
      end else begin
        if (m_cur_k - last_rise < min_gap) min_gap = m_cur_k - last_rise;
        if (m_cur_k - last_rise > max_gap) max_gap = m_cur_k - last_rise;
      end
      last_rise = m_cur_k;
      rises++;
      hi_len = 0;
    end
    if (bus.signal) hi_len++;
    if (!bus.signal && prev_sig && m_cur_k != -1) check_eq("high_time", hi_len, PW);
    prev_sig = bus.signal;
  endtask

  task automatic step(input logic rst, input logic ld, input int f);
    reset         = rst;
    bus.freq_load = ld;
    bus.freq      = 7'(f);
    @(posedge clk);
    model_edge(rst, ld, f);
    @(negedge clk);
    observe();
  endtask

  // Run one full window; up to three loads at given window cycles (-1 = unused).
  task automatic drive_window(input int k1, input int f1, input int k2, input int f2,
                              input int k3, input int f3);
    for (int i = 0; i < P; i++) begin
      if (m_k == k1)      step(1'b0, 1'b1, f1);
      else if (m_k == k2) step(1'b0, 1'b1, f2);
      else if (m_k == k3) step(1'b0, 1'b1, f3);
      else                step(1'b0, 1'b0, $urandom_range(0, 127));
    end
  endtask

  initial begin
    int  c1;
    int  c2;
    int  fbig;
    bit  found;
    reset         = 1'b1;
    bus.freq      = '0;
    bus.freq_load = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);

    // W0: no edges; 37 is the last of three loads. W1: 37 edges.
    drive_window(1, 5, 3, 8, 5, 37);
    check_eq("w0_active_freq_end", int'(bus.active_freq), 0);
    // W1 loads 5 then an out-of-range value; the clamped 99 must win.
    c1   = $urandom_range(1, 5000);
    c2   = $urandom_range(5001, P - 2);
    fbig = $urandom_range(100, 127);
    drive_window(c1, 5, c2, fbig, -1, 0);
    check_eq("w1_active_freq_end", int'(bus.active_freq), 37);
    // W2 runs 99; 8 then 10 at the last cycle -> W3 runs 10.
    drive_window($urandom_range(1, 6000), 8, P - 1, 10, -1, 0);
    check_eq("w2_active_freq_end", int'(bus.active_freq), 99);
    // W3 runs 10; load 20 in cycle 0 applies to W4.
    drive_window(0, 20, -1, 0, -1, 0);
    check_eq("w3_active_freq_end", int'(bus.active_freq), 10);

    // W4: wait for a high pulse mid-window, then reset for 3 cycles.
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      step(1'b0, 1'b0, 0);
      if (bus.signal && m_cur_k > 3000) found = 1'b1;
    end
    check_eq("pulse_found_before_reset", int'(found), 1);
    check_eq("w4_active_freq", int'(bus.active_freq), 20);
    step(1'b1, 1'b0, 0);
    check_eq("reset_signal", int'(bus.signal), 0);
    check_eq("reset_active_freq", int'(bus.active_freq), 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    check_eq("reset_window_start", int'(bus.window_start), 0);

    // Post-reset W0: window_start in the first cycle, no edges; explicit freq=0 load.
    step(1'b0, 1'b0, 0);
    check_eq("ws_after_reset", int'(bus.window_start), 1);
    for (int i = 1; i < P; i++) begin
      if (m_k == 3) step(1'b0, 1'b1, 0);
      else          step(1'b0, 1'b0, $urandom_range(0, 127));
    end
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 0);
    check_eq("after_zero_active_freq", int'(bus.active_freq), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
